id_ex_forward_stage: RTL
========================

# id_ex_forward_stage

ID/EX pipeline register with integrated load-use hazard detection and operand-forwarding select generation. Captures decoded operands and control from the ID stage each cycle, inserts bubbles on load-use hazards or branch flush, and drives the 2-bit selects of the two EX-stage 3:1 operand muxes (register file / EX-MEM / MEM-WB). Sits between the decoder/register file and the EX-stage operand muxes feeding the ALU.

## Interface
- DATAWIDTH, 32, operand/immediate width
- REGADDR, 5, register index width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID slot holds a real instruction
- id_rs1, id_rs2, id_rd  in  REGADDR  source/destination indices
- id_rs1_data, id_rs2_data  in  DATAWIDTH  register file read data
- id_imm  in  DATAWIDTH  decoded immediate
- id_reg_write, id_mem_read  in  1  control bits of ID instruction
- flush  in  1  branch/jump resolved taken in EX; kill ID instruction
- mem_rd  in  REGADDR, mem_reg_write  in  1  EX/MEM destination info
- wb_rd  in  REGADDR, wb_reg_write  in  1  MEM/WB destination info
- ex_valid  out  1  EX slot valid
- ex_rs1, ex_rs2, ex_rd  out  REGADDR  registered indices
- ex_rs1_data, ex_rs2_data, ex_imm  out  DATAWIDTH  registered operands
- ex_reg_write, ex_mem_read  out  1  registered control (forced 0 in a bubble)
- fwd_a_sel, fwd_b_sel  out  2  operand mux selects: 00 regfile, 01 EX/MEM, 10 MEM/WB
- stall  out  1  hold PC and IF/ID register this cycle
- bubble_count  out  32  saturating count of inserted bubbles

## Operation
- Load-use hazard (combinational): hazard = id_valid & ex_valid & ex_mem_read & (ex_rd != 0) & (ex_rd == id_rs1 | ex_rd == id_rs2).
- stall = hazard & ~flush. Flush wins: wrong-path instruction is discarded, never stalled.
- Register update each rising edge:
  - flush or hazard: bubble — ex_valid, ex_reg_write, ex_mem_read <= 0; index/data fields <= 0.
  - otherwise: capture all id_* fields; ex_valid <= id_valid; control bits gated by id_valid.
- Forwarding (combinational from registered ex_* and live mem_*/wb_*), per operand X in {rs1→a, rs2→b}:
  - 01 if mem_reg_write & mem_rd != 0 & mem_rd == ex_X.
  - else 10 if wb_reg_write & wb_rd != 0 & wb_rd == ex_X.
  - else 00. Code 11 is never produced.
  - ex_valid = 0 forces both selects to 00.
- bubble_count increments by 1 on each clock edge where a bubble is inserted due to hazard with no flush (stall asserted); flush bubbles are not counted; saturates at 32'hFFFF_FFFF.

## Timing
- Reset (async, rst_n low): all ex_* outputs 0, ex_valid 0, bubble_count 0; hence fwd selects 00 and stall 0 while in reset. Reset takes effect immediately, mid-operation included; first capture on first rising edge after rst_n deasserts.
- Latency: id_* to ex_* one cycle.
- stall, fwd_a_sel, fwd_b_sel: same-cycle combinational, no registered delay.
- Load-use: stall asserted exactly one cycle per hazard; next cycle ex_mem_read = 0 so hazard clears and held ID instruction enters EX with MEM/WB... forward (select 10) from the load.
- Simultaneous flush and hazard: bubble, stall 0, counter unchanged.

## Structure
- Shared package: fwd select constants FWD_REG=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10; REGADDR default; zero-register index constant.
- One sub-module natural: fwd_select_unit (pure combinational, instantiated twice, one per operand).

## Test plan
- Reset mid-stream: rst_n low with ex_valid=1, ex_rd=5 → all outputs 0 immediately, bubble_count 0.
- Pass-through: id_valid=1, rs1=3, rs1_data=0x1234, imm=0x10, no hazards → next cycle ex_rs1_data=0x1234, ex_imm=0x10, sels 00.
- Forward priority: ex_rs1=7, mem_rd=7/mem_reg_write=1, wb_rd=7/wb_reg_write=1 → fwd_a_sel=01; drop mem_reg_write → 10; mem_rd=0 with reg_write → never 01.
- Load-use: EX holds lw to x4 (ex_mem_read=1), ID reads rs2=4 → stall=1 one cycle, bubble enters EX, bubble_count=1; following cycle stall=0, and with wb_rd=4 fwd_b_sel=10.
- Flush vs hazard: same load-use plus flush=1 → stall=0, bubble inserted, bubble_count unchanged.
- Saturation: preload via 2^32−1 hazards (or force) → further hazards hold bubble_count at 0xFFFF_FFFF.

Source files
------------

// File: rtl/id_ex_forward_stage_pkg.sv
// Shared constants for the ID/EX stage: forwarding select codes and register-index defaults.
package id_ex_forward_stage_pkg;

    localparam int unsigned REGADDR_DEF = 5;
    localparam int unsigned ZERO_REG    = 0;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_REG   = 2'b00;
    localparam fwd_sel_t FWD_EXMEM = 2'b01;
    localparam fwd_sel_t FWD_MEMWB = 2'b10;

endpackage

// File: rtl/id_ex_forward_stage_fwd_select_unit.sv
// Operand forwarding select for one EX-stage source: EX/MEM beats MEM/WB, x0 never forwards.
module id_ex_forward_stage_fwd_select_unit
    import id_ex_forward_stage_pkg::*;
#(
    parameter int unsigned REGADDR = REGADDR_DEF
) (
    input  logic               i_ex_valid,
    input  logic [REGADDR-1:0] i_ex_rs,
    input  logic [REGADDR-1:0] i_mem_rd,
    input  logic               i_mem_reg_write,
    input  logic [REGADDR-1:0] i_wb_rd,
    input  logic               i_wb_reg_write,
    output fwd_sel_t           o_sel
);

    logic w_mem_hit;
    logic w_wb_hit;

    assign w_mem_hit = i_mem_reg_write && (i_mem_rd != REGADDR'(ZERO_REG)) && (i_mem_rd == i_ex_rs);
    assign w_wb_hit  = i_wb_reg_write && (i_wb_rd != REGADDR'(ZERO_REG)) && (i_wb_rd == i_ex_rs);

    always_comb begin
        o_sel = FWD_REG;
        if (i_ex_valid) begin
            if (w_mem_hit) begin
                o_sel = FWD_EXMEM;
            end else if (w_wb_hit) begin
                o_sel = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/id_ex_forward_stage.sv
// ID/EX pipeline register with load-use stall, flush bubbles, bubble counter and
// forwarding-select generation for the two EX operand muxes.
module id_ex_forward_stage
    import id_ex_forward_stage_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned REGADDR   = REGADDR_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_id_valid,
    input  logic [REGADDR-1:0]   i_id_rs1,
    input  logic [REGADDR-1:0]   i_id_rs2,
    input  logic [REGADDR-1:0]   i_id_rd,
    input  logic [DATAWIDTH-1:0] i_id_rs1_data,
    input  logic [DATAWIDTH-1:0] i_id_rs2_data,
    input  logic [DATAWIDTH-1:0] i_id_imm,
    input  logic                 i_id_reg_write,
    input  logic                 i_id_mem_read,
    input  logic                 i_flush,
    input  logic [REGADDR-1:0]   i_mem_rd,
    input  logic                 i_mem_reg_write,
    input  logic [REGADDR-1:0]   i_wb_rd,
    input  logic                 i_wb_reg_write,
    output logic                 o_ex_valid,
    output logic [REGADDR-1:0]   o_ex_rs1,
    output logic [REGADDR-1:0]   o_ex_rs2,
    output logic [REGADDR-1:0]   o_ex_rd,
    output logic [DATAWIDTH-1:0] o_ex_rs1_data,
    output logic [DATAWIDTH-1:0] o_ex_rs2_data,
    output logic [DATAWIDTH-1:0] o_ex_imm,
    output logic                 o_ex_reg_write,
    output logic                 o_ex_mem_read,
    output fwd_sel_t             o_fwd_a_sel,
    output fwd_sel_t             o_fwd_b_sel,
    output logic                 o_stall,
    output logic [31:0]          o_bubble_count
);

    logic                 r_ex_valid;
    logic [REGADDR-1:0]   r_ex_rs1;
    logic [REGADDR-1:0]   r_ex_rs2;
    logic [REGADDR-1:0]   r_ex_rd;
    logic [DATAWIDTH-1:0] r_ex_rs1_data;
    logic [DATAWIDTH-1:0] r_ex_rs2_data;
    logic [DATAWIDTH-1:0] r_ex_imm;
    logic                 r_ex_reg_write;
    logic                 r_ex_mem_read;
    logic [31:0]          r_bubble_count;

    logic w_hazard;
    logic w_bubble;

    assign w_hazard = i_id_valid && r_ex_valid && r_ex_mem_read &&
                      (r_ex_rd != REGADDR'(ZERO_REG)) &&
                      ((r_ex_rd == i_id_rs1) || (r_ex_rd == i_id_rs2));
    // A flushed wrong-path instruction is dropped, so it must never hold the front end.
    assign o_stall  = w_hazard && !i_flush;
    assign w_bubble = w_hazard || i_flush;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ex_valid     <= 1'b0;
            r_ex_rs1       <= '0;
            r_ex_rs2       <= '0;
            r_ex_rd        <= '0;
            r_ex_rs1_data  <= '0;
            r_ex_rs2_data  <= '0;
            r_ex_imm       <= '0;
            r_ex_reg_write <= 1'b0;
            r_ex_mem_read  <= 1'b0;
        end else if (w_bubble) begin
            r_ex_valid     <= 1'b0;
            r_ex_rs1       <= '0;
            r_ex_rs2       <= '0;
            r_ex_rd        <= '0;
            r_ex_rs1_data  <= '0;
            r_ex_rs2_data  <= '0;
            r_ex_imm       <= '0;
            r_ex_reg_write <= 1'b0;
            r_ex_mem_read  <= 1'b0;
        end else begin
            r_ex_valid     <= i_id_valid;
            r_ex_rs1       <= i_id_rs1;
            r_ex_rs2       <= i_id_rs2;
            r_ex_rd        <= i_id_rd;
            r_ex_rs1_data  <= i_id_rs1_data;
            r_ex_rs2_data  <= i_id_rs2_data;
            r_ex_imm       <= i_id_imm;
            r_ex_reg_write <= i_id_reg_write && i_id_valid;
            r_ex_mem_read  <= i_id_mem_read && i_id_valid;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bubble_count <= '0;
        end else if (o_stall && (r_bubble_count != '1)) begin
            r_bubble_count <= r_bubble_count + 32'd1;
        end
    end

    id_ex_forward_stage_fwd_select_unit #(
        .REGADDR (REGADDR)
    ) u_fwd_a (
        .i_ex_valid      (r_ex_valid),
        .i_ex_rs         (r_ex_rs1),
        .i_mem_rd        (i_mem_rd),
        .i_mem_reg_write (i_mem_reg_write),
        .i_wb_rd         (i_wb_rd),
        .i_wb_reg_write  (i_wb_reg_write),
        .o_sel           (o_fwd_a_sel)
    );

    id_ex_forward_stage_fwd_select_unit #(
        .REGADDR (REGADDR)
    ) u_fwd_b (
        .i_ex_valid      (r_ex_valid),
        .i_ex_rs         (r_ex_rs2),
        .i_mem_rd        (i_mem_rd),
        .i_mem_reg_write (i_mem_reg_write),
        .i_wb_rd         (i_wb_rd),
        .i_wb_reg_write  (i_wb_reg_write),
        .o_sel           (o_fwd_b_sel)
    );

    assign o_ex_valid     = r_ex_valid;
    assign o_ex_rs1       = r_ex_rs1;
    assign o_ex_rs2       = r_ex_rs2;
    assign o_ex_rd        = r_ex_rd;
    assign o_ex_rs1_data  = r_ex_rs1_data;
    assign o_ex_rs2_data  = r_ex_rs2_data;
    assign o_ex_imm       = r_ex_imm;
    assign o_ex_reg_write = r_ex_reg_write;
    assign o_ex_mem_read  = r_ex_mem_read;
    assign o_bubble_count = r_bubble_count;

endmodule
